// File: rtl/riscv_encode.sv
// RV32I instruction encoder: packs field bundles into 32-bit words, checks the
// immediate, tags each word with a sequential PC and queues it in a 2-entry FIFO.
module riscv_encode (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [2:0]  fmt_i,
   input  logic [6:0]  op_i,
   input  logic [4:0]  rd_i,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   input  logic [2:0]  funct3_i,
   input  logic [6:0]  funct7_i,
   input  logic [31:0] imm_i,
   input  logic        pc_load_i,
   input  logic [31:0] pc_base_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic        err_o,
   output logic [1:0]  err_code_o
);

   localparam int DATA_W = 32;

   localparam logic [2:0] FMT_R = 3'd0;
   localparam logic [2:0] FMT_I = 3'd1;
   localparam logic [2:0] FMT_S = 3'd2;
   localparam logic [2:0] FMT_B = 3'd3;
   localparam logic [2:0] FMT_U = 3'd4;
   localparam logic [2:0] FMT_J = 3'd5;

   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_FMT   = 2'd1;
   localparam logic [1:0] ERR_RANGE = 2'd2;
   localparam logic [1:0] ERR_ALIGN = 2'd3;

   function automatic logic [DATA_W-1:0] pack_word(
      input logic [2:0]        fmt,
      input logic [6:0]        op,
      input logic [4:0]        rd,
      input logic [4:0]        rs1,
      input logic [4:0]        rs2,
      input logic [2:0]        f3,
      input logic [6:0]        f7,
      input logic [DATA_W-1:0] imm
   );
      logic [DATA_W-1:0] w;
      w = '0;
      case (fmt)
         FMT_R:   w = {f7, rs2, rs1, f3, rd, op};
         FMT_I:   w = {imm[11:0], rs1, f3, rd, op};
         FMT_S:   w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
         FMT_B:   w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
         FMT_U:   w = {imm[31:12], rd, op};
         FMT_J:   w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
         default: w = '0;
      endcase
      return w;
   endfunction

   // Priority: illegal format, then alignment, then sign-extension range.
   function automatic logic [1:0] check_imm(
      input logic [2:0]        fmt,
      input logic [DATA_W-1:0] imm
   );
      logic [1:0] code;
      logic       fit11;
      logic       fit12;
      logic       fit20;
      fit11 = (imm[31:11] == '0) || (imm[31:11] == '1);
      fit12 = (imm[31:12] == '0) || (imm[31:12] == '1);
      fit20 = (imm[31:20] == '0) || (imm[31:20] == '1);
      code  = ERR_NONE;
      if (fmt > FMT_J)
         code = ERR_FMT;
      else if (((fmt == FMT_B) || (fmt == FMT_J)) && imm[0])
         code = ERR_ALIGN;
      else if ((fmt == FMT_U) && (imm[11:0] != '0))
         code = ERR_ALIGN;
      else if (((fmt == FMT_I) || (fmt == FMT_S)) && !fit11)
         code = ERR_RANGE;
      else if ((fmt == FMT_B) && !fit12)
         code = ERR_RANGE;
      else if ((fmt == FMT_J) && !fit20)
         code = ERR_RANGE;
      return code;
   endfunction

   logic [1:0]        count_q;
   logic              rd_ptr_q;
   logic              wr_ptr_q;
   logic [DATA_W-1:0] instr_mem_q [2];
   logic [DATA_W-1:0] pc_mem_q [2];
   logic [DATA_W-1:0] pc_q;
   logic              err_q;
   logic [1:0]        err_code_q;

   logic              accept_p0;
   logic [1:0]        code_p0;
   logic              vld_p0;
   logic              rej_p0;
   logic              pop_p1;
   logic [DATA_W-1:0] base_p0;
   logic [DATA_W-1:0] pc_word_p0;
   logic [DATA_W-1:0] word_p0;

   // p0: request decode, check and packing (combinational from inputs)
   assign req_ready_o = (count_q < 2'd2);
   assign accept_p0   = req_valid_i & req_ready_o;
   assign code_p0     = check_imm(fmt_i, imm_i);
   assign vld_p0      = accept_p0 & (code_p0 == ERR_NONE);
   assign rej_p0      = accept_p0 & (code_p0 != ERR_NONE);
   assign base_p0     = pc_base_i & 32'hFFFF_FFFC;
   assign pc_word_p0  = pc_load_i ? base_p0 : pc_q;
   assign word_p0     = pack_word(fmt_i, op_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i);

   // p1: FIFO head and error status, all registered
   assign pop_p1      = (count_q != 2'd0) & out_ready_i;
   assign out_valid_o = (count_q != 2'd0);
   assign instr_o     = instr_mem_q[rd_ptr_q];
   assign pc_o        = pc_mem_q[rd_ptr_q];
   assign err_o       = err_q;
   assign err_code_o  = err_code_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count_q    <= 2'd0;
         rd_ptr_q   <= 1'b0;
         wr_ptr_q   <= 1'b0;
         pc_q       <= '0;
         err_q      <= 1'b0;
         err_code_q <= ERR_NONE;
         for (int i = 0; i < 2; i++) begin
            instr_mem_q[i] <= '0;
            pc_mem_q[i]    <= '0;
         end
      end else begin
         if (vld_p0) begin
            instr_mem_q[wr_ptr_q] <= word_p0;
            pc_mem_q[wr_ptr_q]    <= pc_word_p0;
            wr_ptr_q              <= ~wr_ptr_q;
         end
         if (pop_p1)
            rd_ptr_q <= ~rd_ptr_q;
         case ({vld_p0, pop_p1})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
         // A load with a rejected (or absent) request still retargets the PC.
         if (vld_p0)
            pc_q <= pc_word_p0 + 32'd4;
         else if (pc_load_i)
            pc_q <= base_p0;
         err_q <= rej_p0;
         if (rej_p0)
            err_code_q <= code_p0;
      end
   end

endmodule

// File: tb/tb_riscv_encode.sv
// Scoreboard bench for riscv_encode: driver pushes model-predicted words, a
// negedge monitor pops and compares whenever the FIFO head is valid.
`timescale 1ns/1ps
module tb_riscv_encode;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  fmt;
   logic [6:0]  op;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm;
   logic        pc_load;
   logic [31:0] pc_base;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] instr;
   logic [31:0] pc;
   logic        err;
   logic [1:0]  err_code;

   bit   rand_rdy = 1'b0;
   logic rnd_rdy  = 1'b1;
   logic dir_rdy  = 1'b0;
   assign out_ready = rand_rdy ? rnd_rdy : dir_rdy;

   always #5 clk = ~clk;

   riscv_encode dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .fmt_i(fmt), .op_i(op), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2),
      .funct3_i(f3), .funct7_i(f7), .imm_i(imm),
      .pc_load_i(pc_load), .pc_base_i(pc_base),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .instr_o(instr), .pc_o(pc),
      .err_o(err), .err_code_o(err_code)
   );

   typedef struct { logic [31:0] instr; logic [31:0] pc; } exp_t;
   exp_t exp_q[$];

   int          checks = 0;
   int          errors = 0;
   logic [31:0] pc_m = 32'd0;
   bit          rej_next = 1'b0;
   logic [1:0]  code_next = 2'd0;
   logic        exp_err = 1'b0;
   logic [1:0]  exp_code = 2'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%08h required=%08h", name, act, req);
      end
   endtask

   // Reference encoding from the ISA bit positions, built with shifts and masks.
   function automatic logic [31:0] ref_word(input logic [2:0] fm, input logic [31:0] o,
         input logic [31:0] d, input logic [31:0] s1, input logic [31:0] s2,
         input logic [31:0] g3, input logic [31:0] g7, input logic [31:0] im);
      logic [31:0] w;
      w = o;
      case (fm)
         3'd0: w = w | (d << 7) | (g3 << 12) | (s1 << 15) | (s2 << 20) | (g7 << 25);
         3'd1: w = w | (d << 7) | (g3 << 12) | (s1 << 15) | ((im & 32'hFFF) << 20);
         3'd2: w = w | ((im & 32'h1F) << 7) | (g3 << 12) | (s1 << 15) | (s2 << 20)
                     | (((im >> 5) & 32'h7F) << 25);
         3'd3: w = w | (((im >> 11) & 32'h1) << 7) | (((im >> 1) & 32'hF) << 8)
                     | (g3 << 12) | (s1 << 15) | (s2 << 20)
                     | (((im >> 5) & 32'h3F) << 25) | (((im >> 12) & 32'h1) << 31);
         3'd4: w = w | (d << 7) | (im & 32'hFFFF_F000);
         default: w = w | (d << 7) | (((im >> 12) & 32'hFF) << 12) | (((im >> 11) & 32'h1) << 20)
                     | (((im >> 1) & 32'h3FF) << 21) | (((im >> 20) & 32'h1) << 31);
      endcase
      return w;
   endfunction

   function automatic logic [1:0] ref_code(input logic [2:0] fm, input logic [31:0] im);
      int s;
      s = im;
      if (fm > 3'd5) return 2'd1;
      if ((fm == 3'd3 || fm == 3'd5) && (im % 2 != 0)) return 2'd3;
      if (fm == 3'd4 && (im & 32'hFFF) != 0) return 2'd3;
      if ((fm == 3'd1 || fm == 3'd2) && (s < -2048 || s > 2047)) return 2'd2;
      if (fm == 3'd3 && (s < -4096 || s > 4095)) return 2'd2;
      if (fm == 3'd5 && (s < -1048576 || s > 1048575)) return 2'd2;
      return 2'd0;
   endfunction

   always @(posedge clk) begin
      if (!reset_n) begin
         exp_err  <= 1'b0;
         exp_code <= 2'd0;
      end else begin
         exp_err <= rej_next;
         if (rej_next) exp_code <= code_next;
      end
   end

   always @(posedge clk) begin
      #1;
      rnd_rdy = ($urandom_range(0, 3) != 0);
   end

   // Monitor: compare head against scoreboard, pop when the consumer takes it.
   always @(negedge clk) begin
      if (reset_n === 1'b1) begin
         chk("err_o", {31'd0, err}, {31'd0, exp_err});
         chk("err_code_o", {30'd0, err_code}, {30'd0, exp_code});
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word actual=%08h/%08h required=none", instr, pc);
            end else begin
               chk("instr_o", instr, exp_q[0].instr);
               chk("pc_o", pc, exp_q[0].pc);
               if (out_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input logic [2:0] fm, input logic [6:0] o, input logic [4:0] d,
         input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] g3,
         input logic [6:0] g7, input logic [31:0] im, input bit pl, input logic [31:0] base,
         input bit use_lit, input logic [31:0] lit);
      int         waited;
      bit         done;
      logic [1:0] c;
      logic [31:0] p;
      exp_t       e;
      waited = 0;
      done = 1'b0;
      fmt = fm; op = o; rd = d; rs1 = s1; rs2 = s2; f3 = g3; f7 = g7; imm = im;
      pc_load = pl; pc_base = base; req_valid = 1'b1;
      while (!done) begin
         @(negedge clk);
         if (req_ready) begin
            c = ref_code(fm, im);
            p = pl ? (base & 32'hFFFF_FFFC) : pc_m;
            if (c != 2'd0) begin
               rej_next = 1'b1;
               code_next = c;
               if (pl) pc_m = p;
            end else begin
               e.instr = use_lit ? lit : ref_word(fm, o, d, s1, s2, g3, g7, im);
               e.pc = p;
               exp_q.push_back(e);
               pc_m = p + 32'd4;
            end
            done = 1'b1;
         end else begin
            if (pl) pc_m = base & 32'hFFFF_FFFC;
            waited++;
            if (waited > 200) begin
               checks++;
               errors++;
               $display("FAIL send_timeout actual=stalled required=accept");
               req_valid = 1'b0;
               done = 1'b1;
            end
         end
         @(posedge clk);
         #1;
         rej_next = 1'b0;
      end
      req_valid = 1'b0;
      pc_load = 1'b0;
   endtask

   task automatic idle(input int n);
      req_valid = 1'b0;
      pc_load = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pc_only(input logic [31:0] base);
      pc_load = 1'b1;
      pc_base = base;
      @(negedge clk);
      pc_m = base & 32'hFFFF_FFFC;
      @(posedge clk);
      #1;
      pc_load = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      time         t0;
      logic [2:0]  rf;
      logic [31:0] ri;
      int          v;
      reset_n = 1'b0; req_valid = 1'b0; fmt = 3'd0; op = 7'd0; rd = 5'd0; rs1 = 5'd0;
      rs2 = 5'd0; f3 = 3'd0; f7 = 7'd0; imm = 32'd0; pc_load = 1'b0; pc_base = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(negedge clk);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_pc", pc, 32'd0);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      #1;

      // Basic R then a second word at pc 4
      dir_rdy = 1'b1;
      send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h002081B3);
      @(negedge clk);
      chk("first_latency_valid", {31'd0, out_valid}, 32'd1);
      @(posedge clk);
      #1;
      send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h002081B3);
      idle(3);

      // Stream one per cycle across all formats
      pc_only(32'd0);
      t0 = $time;
      send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,  1'b0, 32'd0, 1'b1, 32'h00500093);
      send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,  1'b0, 32'd0, 1'b1, 32'h0020A423);
      send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8,  1'b0, 32'd0, 1'b1, 32'h00208463);
      send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd16, 1'b0, 32'd0, 1'b1, 32'h010000EF);
      send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b0, 32'd0, 1'b1, 32'h123452B7);
      chk("stream_cycles", 32'((($time - t0) / 10)), 32'd5);
      idle(3);

      // Backpressure: fill, stall third, release
      dir_rdy = 1'b0;
      send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0, 32'd0, 1'b0, 32'd0);
      send(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 1'b0, 32'd0, 1'b0, 32'd0);
      @(negedge clk);
      chk("full_req_ready", {31'd0, req_ready}, 32'd0);
      chk("full_out_valid", {31'd0, out_valid}, 32'd1);
      @(posedge clk);
      #1;
      fork
         send(3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1'b0, 32'd0, 1'b0, 32'd0);
         begin
            repeat (3) @(posedge clk);
            #1;
            dir_rdy = 1'b1;
         end
      join
      idle(4);

      // Back-to-back rejects, then a legal word must not see a PC advance
      send(3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0,         1'b0, 32'd0, 1'b0, 32'd0);
      send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800,       1'b0, 32'd0, 1'b0, 32'd0);
      send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd7,         1'b0, 32'd0, 1'b0, 32'd0);
      send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1000_0001, 1'b0, 32'd0, 1'b0, 32'd0);
      idle(2);
      send(3'd1, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800, 1'b0, 32'd0, 1'b0, 32'd0);
      idle(2);

      // PC load with accept, load with reject, and wrap
      send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1, 32'h1003, 1'b0, 32'd0);
      send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0, 32'd0,    1'b0, 32'd0);
      send(3'd7, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1, 32'h2002, 1'b0, 32'd0);
      send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0, 32'd0,    1'b0, 32'd0);
      pc_only(32'hFFFF_FFFC);
      send(3'd0, 7'h33, 5'd7, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      send(3'd0, 7'h33, 5'd8, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      idle(3);

      // Randomized traffic with random consumer backpressure
      rand_rdy = 1'b1;
      for (int n = 0; n < 400; n++) begin
         idle($urandom_range(0, 1));
         rf = ($urandom_range(0, 9) == 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 5));
         case ($urandom_range(0, 4))
            0: begin v = int'($urandom_range(0, 8191)) - 4096;       ri = 32'(v); end
            1: begin v = int'($urandom_range(0, 16383)) - 8192;      ri = 32'(v) & ~32'd1; end
            2: ri = $urandom();
            3: ri = $urandom() & 32'hFFFF_F000;
            default: begin v = int'($urandom_range(0, 4194303)) - 2097152; ri = 32'(v) & ~32'd1; end
         endcase
         send(rf, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
              7'($urandom), ri, ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 | 32'($urandom_range(0, 7)) : $urandom(),
              1'b0, 32'd0);
      end
      rand_rdy = 1'b0;
      dir_rdy = 1'b1;
      idle(6);
      chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);

      // Reset with two words queued and an error pending
      dir_rdy = 1'b0;
      send(3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9, 1'b0, 32'd0, 1'b0, 32'd0);
      send(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9, 1'b0, 32'd0, 1'b0, 32'd0);
      reset_n = 1'b0;
      exp_q.delete();
      pc_m = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(negedge clk);
      chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_err", {31'd0, err}, 32'd0);
      chk("mid_rst_err_code", {30'd0, err_code}, 32'd0);
      chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      #1;
      dir_rdy = 1'b1;
      send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h002081B3);
      idle(4);
      chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
